// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand/result handshake bundle for serial_add_ctrl
// Optional ovf signal present when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer sharing one full_adder
// Optional feature macro: SERIAL_ADD_OVF_EN (adds signed overflow flag ovf).
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s1),  .c_o(c1));
  half_adder u_ha1 (.a_i(s1),  .b_i(c_i), .s_o(s_o), .c_o(c2));
  assign c_o = c1 | c2;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a_i(a_sr_q[0]),
    .b_i(b_sr_q[0]),
    .c_i(carry_q),
    .s_o(fa_s),
    .c_o(fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign bus.ovf = ovf_q;
`else
  assign ovf_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is positioned 1 time unit after a rising edge with the block in IDLE.
  task automatic do_add(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                        input int stall, input logic [7:0] esum, input logic ecout,
                        input logic eovf, input bit pulse);
    int cycles;
    bus.a        = ta;
    bus.b        = tb;
    bus.cin      = tcin;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("accept_busy", 32'(bus.busy), 32'd1);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check("latency", 32'(cycles), 32'd8);
    check("sum", 32'(bus.sum), 32'(esum));
    check("cout", 32'(bus.cout), 32'(ecout));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", 32'(bus.ovf), 32'(eovf));
`endif
    for (int i = 0; i < stall; i++) begin
      if (pulse && i == 2) begin
        bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_ready", 32'(bus.in_ready), 32'd0);
      check("stall_sum", 32'(bus.sum), 32'(esum));
      check("stall_cout", 32'(bus.cout), 32'(ecout));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_sum_held", 32'(bus.sum), 32'(esum));
    tick();
    check("idle_no_rerun", 32'(bus.busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         stall;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    bit         pulse;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [8:0] model;
    logic [7:0] ra, rb;
    logic       rc, rovf;
    checks   = 0;
    failures = 0;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 8'h5A, 1'b1, 5, 8'h97, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h05, 8'h03, 1'b0, 0, 8'h08, 1'b0, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall,
             vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].pulse);
    end

    // Reset three cycles into RUN abandons the add.
    bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    check("midrun_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_sum", 32'(bus.sum), 32'd0);
    check("arst_cout", 32'(bus.cout), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_add(8'h12, 8'h34, 1'b0, 0, 8'h46, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rc    = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      rovf  = (ra[7] == rb[7]) && (model[7] != ra[7]);
      do_add(ra, rb, rc, int'($urandom_range(0, 3)), model[7:0], model[8], rovf, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
